// File: rtl/pll_reset_sequencer.sv
// Brings an rPLL out of reset, qualifies its lock, then releases the downstream reset.
// Retries on lock timeout, faults when retries run out, and re-sequences on ODSEL changes.
module pll_reset_sequencer #(
    parameter int         RST_CYCLES    = 16,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         MAX_RETRY     = 3,
    parameter logic [5:0] ODSEL_INIT    = 6'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_odsel,
    input  logic       cfg_req,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    // One shared phase counter, wide enough for the longest of the three intervals.
    localparam int MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]    RETRY_LIMIT  = 5'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PLLRST,
        ST_WAIT,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_meta;
    logic          lock_s;
    logic [4:0]    retry_inc;

    // Extra bit lets MAX_RETRY=15 still fault even though retry_count saturates at 15.
    assign retry_inc = {1'b0, retry_count} + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_PLLRST;
            cnt         <= '0;
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            cfg_ack     <= 1'b0;
            retry_count <= 4'd0;
            pll_odsel   <= ODSEL_INIT;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            cfg_ack   <= 1'b0;
            cnt       <= cnt + CW'(1);
            case (state)
                ST_PLLRST: begin
                    if (cnt == RST_LAST) begin
                        state     <= ST_WAIT;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt         <= '0;
                        pll_reset   <= 1'b1;
                        retry_count <= retry_inc[4] ? 4'd15 : retry_inc[3:0];
                        if (retry_inc > RETRY_LIMIT) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= ST_PLLRST;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        sys_reset   <= 1'b0;
                        ready       <= 1'b1;
                        retry_count <= 4'd0;
                    end
                end
                // A configuration request outranks a simultaneous lock loss.
                ST_RUN, ST_FAULT: begin
                    cnt <= '0;
                    if (cfg_req) begin
                        state       <= ST_PLLRST;
                        pll_odsel   <= cfg_odsel;
                        cfg_ack     <= 1'b1;
                        retry_count <= 4'd0;
                        fault       <= 1'b0;
                        pll_reset   <= 1'b1;
                        sys_reset   <= 1'b1;
                        ready       <= 1'b0;
                    end else if (state == ST_RUN && !lock_s) begin
                        state     <= ST_PLLRST;
                        pll_reset <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_PLLRST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    sys_reset <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/cfg traffic,
// every cycle compared against a phase/age model of the sequencing rules.
module tb_pll_reset_sequencer;

    localparam int         RST_CYCLES    = 4;
    localparam int         STABLE_CYCLES = 8;
    localparam int         LOCK_TIMEOUT  = 20;
    localparam int         MAX_RETRY     = 2;
    localparam logic [5:0] ODSEL_INIT    = 6'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pll_lock = 1'b0;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_odsel = 6'd0;
    logic       pll_reset, cfg_ack, sys_reset, ready, fault;
    logic [5:0] pll_odsel;
    logic [3:0] retry_count;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY),
        .ODSEL_INIT   (ODSEL_INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_odsel  (pll_odsel),
        .cfg_req    (cfg_req),
        .cfg_odsel  (cfg_odsel),
        .cfg_ack    (cfg_ack),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the sequencer is in one of five phases; 'age' is cycles spent there.
    typedef enum int {HOLD, SEEK, QUAL, UP, DEAD} phase_t;
    phase_t ph;
    int     age, tries, q1, q2, ls, m_odsel;
    bit     m_ack;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph = HOLD; age = 0; tries = 0; q1 = 0; q2 = 0;
            m_odsel = ODSEL_INIT; m_ack = 1'b0;
        end else begin
            ls = q2; q2 = q1; q1 = pll_lock;
            m_ack = 1'b0;
            if ((ph == UP || ph == DEAD) && cfg_req) begin
                m_odsel = cfg_odsel; m_ack = 1'b1; tries = 0; ph = HOLD; age = 0;
            end else if (ph == HOLD) begin
                age++;
                if (age == RST_CYCLES) begin ph = SEEK; age = 0; end
            end else if (ph == SEEK) begin
                if (ls != 0) begin
                    ph = QUAL; age = 0;
                end else begin
                    age++;
                    if (age == LOCK_TIMEOUT) begin
                        age = 0;
                        ph = (tries + 1 > MAX_RETRY) ? DEAD : HOLD;
                        tries = (tries == 15) ? 15 : tries + 1;
                    end
                end
            end else if (ph == QUAL) begin
                if (ls == 0) begin
                    ph = SEEK; age = 0;
                end else begin
                    age++;
                    if (age == STABLE_CYCLES) begin ph = UP; age = 0; tries = 0; end
                end
            end else if (ph == UP && ls == 0) begin
                ph = HOLD; age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            check_output("pll_reset", pll_reset, int'(ph == HOLD || ph == DEAD));
            check_output("sys_reset", sys_reset, int'(ph != UP));
            check_output("ready", ready, int'(ph == UP));
            check_output("fault", fault, int'(ph == DEAD));
            check_output("cfg_ack", cfg_ack, int'(m_ack));
            check_output("retry_count", retry_count, tries);
            check_output("pll_odsel", pll_odsel, m_odsel);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit);
        for (int i = 0; i < limit && !ready; i++) tick(1);
        check_output("reach_ready", ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_pll_reset"}, pll_reset, 1);
        check_output({tag, "_sys_reset"}, sys_reset, 1);
        check_output({tag, "_ready"}, ready, 0);
        check_output({tag, "_fault"}, fault, 0);
        check_output({tag, "_cfg_ack"}, cfg_ack, 0);
        check_output({tag, "_retry"}, retry_count, 0);
        check_output({tag, "_odsel"}, pll_odsel, ODSEL_INIT);
    endtask

    task automatic apply_stimulus();
        int lock_left;
        // Power-on reset, lock already high: release at edge 13 (4 + sync + 8).
        #1 reset = 1'b1;
        pll_lock = 1'b1;
        tick(2);
        check_reset_values("por");
        reset = 1'b0;
        started = 1'b1;
        tick(3);  check_output("lit_pllrst_held", pll_reset, 1);
        tick(1);  check_output("lit_pllrst_fell", pll_reset, 0);
        tick(8);  check_output("lit_not_ready_e12", ready, 0);
        tick(1);  check_output("lit_ready_e13", ready, 1);
        check_output("lit_sysrst_e13", sys_reset, 0);

        // One-cycle lock glitch late in qualification restarts the stable count.
        reset = 1'b1; tick(1); reset = 1'b0;
        tick(10); pll_lock = 1'b0;
        tick(1);  pll_lock = 1'b1;
        tick(2);  check_output("lit_glitch_no_ready", ready, 0);
        tick(8);  check_output("lit_glitch_e21", ready, 0);
        tick(1);  check_output("lit_glitch_ready_e22", ready, 1);
        check_output("lit_glitch_retry", retry_count, 0);

        // Lock never arrives: three attempts, fault on edge 72.
        reset = 1'b1; pll_lock = 1'b0; tick(1); reset = 1'b0;
        tick(71); check_output("lit_fault_e71", fault, 0);
        check_output("lit_retry_e71", retry_count, 2);
        tick(1);  check_output("lit_fault_e72", fault, 1);
        check_output("lit_retry_e72", retry_count, 3);
        check_output("lit_fault_pllrst", pll_reset, 1);
        tick(5);  check_output("lit_fault_sticky", fault, 1);

        // Configuration accepted out of FAULT.
        cfg_odsel = 6'd12; cfg_req = 1'b1;
        tick(1);  check_output("lit_fault_ack", cfg_ack, 1);
        check_output("lit_fault_odsel", pll_odsel, 12);
        check_output("lit_fault_cleared", fault, 0);
        cfg_req = 1'b0; pll_lock = 1'b1;
        wait_ready(60);

        // Request in RUN, then held through re-sequencing: only re-acked once RUN returns.
        cfg_odsel = 6'd8; cfg_req = 1'b1;
        tick(1);  check_output("lit_run_ack", cfg_ack, 1);
        check_output("lit_run_odsel", pll_odsel, 8);
        check_output("lit_run_sysrst", sys_reset, 1);
        for (int i = 0; i < 60 && !ready; i++) tick(1);
        check_output("lit_held_ready_before_ack", ready, 1);
        check_output("lit_held_no_early_ack", cfg_ack, 0);
        tick(1);  check_output("lit_held_reack", cfg_ack, 1);
        cfg_req = 1'b0;
        wait_ready(60);

        // Lock loss and request land in the same RUN cycle.
        pll_lock = 1'b0;
        tick(2);  cfg_odsel = 6'd21; cfg_req = 1'b1;
        tick(1);  check_output("lit_tie_ack", cfg_ack, 1);
        check_output("lit_tie_odsel", pll_odsel, 21);
        cfg_req = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        tick(6);  check_output("lit_in_wait", pll_reset, 0);
        #2 reset = 1'b1;
        #1 check_reset_values("async");
        tick(1);  reset = 1'b0;

        // Random lock stretches, requests and occasional resets.
        lock_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (lock_left == 0) begin
                pll_lock = ~pll_lock;
                lock_left = pll_lock ? $urandom_range(1, 60) : $urandom_range(1, 30);
            end
            lock_left--;
            if (cfg_req && cfg_ack) cfg_req = 1'b0;
            else if (!cfg_req && $urandom_range(0, 99) < 3) begin
                cfg_req = 1'b1;
                cfg_odsel = 6'($urandom);
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1; tick(1); reset = 1'b0;
            end
            tick(1);
        end
    endtask

    initial begin
        apply_stimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: clk cycles that pll_reset is held high per PLL reset pulse (minimum 2).
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock-high cycles required before release (minimum 1).
REQ-003 Parameter LOCK_TIMEOUT, default 65535: clk cycles allowed for lock after pll_reset falls (minimum 1).
REQ-004 Parameter MAX_RETRY, default 3: PLL reset attempts after the first before fault (1..15).
REQ-005 Parameter ODSEL_INIT, default 6'd0: pll_odsel value after reset.
REQ-006 clk  in  1  reference clock, the 27 MHz PLL input clock; never a PLL output.
REQ-007 reset  in  1  asynchronous, active-high; sole reset.
REQ-008 pll_lock  in  1  rPLL LOCK, asynchronous to clk.
REQ-009 pll_reset  out  1  to rPLL RESET, active-high.
REQ-010 pll_odsel  out  6  to rPLL ODSEL (dynamic output divider).
REQ-011 cfg_req  in  1  level request to apply cfg_odsel.
REQ-012 cfg_odsel  in  6  requested divider code, valid while cfg_req is high.
REQ-013 cfg_ack  out  1  one-cycle acceptance pulse.
REQ-014 sys_reset  out  1  downstream reset, active-high.
REQ-015 ready  out  1  PLL locked and stable.
REQ-016 fault  out  1  retries exhausted.
REQ-017 retry_count  out  4  attempts that failed since the last RUN entry or accepted cfg_req, saturating at 15.

Function
REQ-018 pll_lock SHALL pass a 2-flop synchronizer, lock_s; all decisions SHALL use lock_s only.
REQ-019 All outputs SHALL be registered. States: PLLRST, WAIT, STABLE, RUN, FAULT.
REQ-020 PLLRST: pll_reset=1, sys_reset=1, ready=0; after RST_CYCLES cycles in PLLRST -> WAIT.
REQ-021 WAIT: pll_reset=0; lock_s=1 -> STABLE; LOCK_TIMEOUT cycles elapsed without lock -> timeout.
REQ-022 On timeout, retry_count SHALL increment; if the incremented value exceeds MAX_RETRY -> FAULT, else -> PLLRST.
REQ-023 STABLE: counts consecutive lock_s=1 cycles; lock_s=0 -> WAIT with the timeout counter restarted and no retry increment; STABLE_CYCLES reached -> RUN.
REQ-024 RUN: sys_reset=0, ready=1, retry_count cleared on entry; lock_s=0 -> PLLRST, with sys_reset=1 and ready=0 on the cycle after lock_s is first seen low.
REQ-025 FAULT: pll_reset=1, sys_reset=1, ready=0, fault=1; exit only via reset or an accepted cfg_req.
REQ-026 cfg_req SHALL be accepted only in RUN or FAULT: pll_odsel<=cfg_odsel, cfg_ack=1 for exactly one cycle, retry_count<=0, fault<=0, -> PLLRST.
REQ-027 cfg_req in PLLRST/WAIT/STABLE SHALL remain pending, not dropped; it is accepted on the first RUN cycle if still high.
REQ-028 The requester SHALL drop cfg_req after cfg_ack; a request still high on re-entry to RUN is a new request.
REQ-029 cfg_req and lock loss in the same RUN cycle: cfg_req wins (ack, new odsel, PLLRST).
REQ-030 pll_odsel SHALL change only on cfg_req acceptance, so it is always stable while pll_reset is low.
REQ-031 Counters SHALL be sized from their parameters and clear on every state entry.

Reset
REQ-032 On reset assertion, asynchronously: state=PLLRST, pll_reset=1, sys_reset=1, ready=0, fault=0, cfg_ack=0, retry_count=0, pll_odsel=ODSEL_INIT, synchronizer flops and counters=0.
REQ-033 After reset deassertion, PLLRST SHALL run a full RST_CYCLES; reset mid-operation restarts the whole sequence.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=20, MAX_RETRY=2)
REQ-034 pll_lock high from reset release -> pll_reset low after 4 cycles; ready=1 and sys_reset=0 at 4+2+8 cycles (±1 registered); retry_count=0.
REQ-035 pll_lock glitch low for 1 cycle at STABLE count 5 -> returns to WAIT, no retry increment; ready only after 8 fresh consecutive lock cycles.
REQ-036 pll_lock held low -> three pll_reset pulses of 4 cycles separated by 20-cycle waits, then fault=1, retry_count=3, pll_reset held 1.
REQ-037 In RUN, cfg_req=1 with cfg_odsel=6'd8 -> cfg_ack single pulse, pll_odsel=8, sys_reset=1, full re-sequence back to ready; cfg_req held through STABLE is not re-acked until RUN.
REQ-038 In RUN, pll_lock drops together with cfg_req=1 -> cfg_ack=1 and pll_odsel updated; async reset pulse mid-WAIT -> all outputs at reset values immediately.
